temporizador_bcd_param: RTL and testbench
=========================================

Name: temporizador_bcd_param

Overview:
- Parametrised successor to the bomb countdown timer: mixed-radix BCD countdown MM..M:SS.d with configurable start value and minute-digit count.
- Internal tenth-of-second prescaler.
- Explicit IDLE/RUNNING/PAUSED/EXPIRED control, a multi-cycle time-penalty engine, and a low-time warning flag.
- Drives the 7-segment digit decoders and the game-over logic.

Parameters:
MIN_DIGITS, 1, number of BCD minute digits (1..3)
TICK_DIV, 100000, CLOCK cycles per tenth-of-second tick (>=1)
START_MIN, 2, start minutes as integer (< 10**MIN_DIGITS)
START_SEC, 59, start seconds as integer (0..59)
START_TENTH, 0, start tenths (0..9)
PENALTY_SEC, 10, seconds subtracted per PENALTY pulse (1..255)
WARN_SEC, 10, warning threshold in seconds (0..59)

Ports:
CLOCK  in  1  system clock
RESET  in  1  synchronous, active-low reset
START  in  1  start/resume/restart request, sampled each edge
PAUSE  in  1  pause request, sampled each edge
PENALTY  in  1  one-cycle pulse: subtract PENALTY_SEC seconds
DECIMOS  out  4  tenths digit, BCD
SEGUNDOS_UNIDADE  out  4  seconds units, BCD
SEGUNDOS_DECIMOS  out  4  seconds tens, BCD 0..5
MINUTOS  out  4*MIN_DIGITS  minute digits, BCD, most-significant digit in the top nibble
RUNNING  out  1  high in RUNNING state
AVISO  out  1  low-time warning
TEMPO_ACABOU  out  1  high in EXPIRED state

Behaviour:
- All state is registered on posedge CLOCK; no asynchronous logic.
- RESET==0 at an edge:
  - digits <= start value (START_MIN converted to BCD at elaboration)
  - state <= IDLE; prescaler <= 0; pending penalty <= 0
  - RUNNING=0, TEMPO_ACABOU=0; AVISO follows its equation (0 in IDLE)
- Priority within RESET==1: PAUSE > START.
- IDLE:
  - digits hold the start value.
  - START -> RUNNING, prescaler <= 0.
  - PAUSE and PENALTY are ignored.
- RUNNING:
  - When pending==0, prescaler counts 0..TICK_DIV-1.
  - On the edge where prescaler==TICK_DIV-1: prescaler <= 0 and the value decrements by one tenth.
  - Borrow chain: tenths 0->9; seconds units 0->9; seconds tens 0->5; each minute digit 0->9, borrowing from the next minute digit.
  - PAUSE -> PAUSED; prescaler holds its count.
  - START is ignored.
- PAUSED:
  - Digits and prescaler hold.
  - START (with PAUSE low) -> RUNNING; counting resumes from the held prescaler count.
- Penalty engine (RUNNING or PAUSED only):
  - PENALTY pulse: pending <= min(pending + PENALTY_SEC, 255). Pending is 8 bits.
  - While pending>0: each edge subtracts exactly one second (seconds units upward; tenths unchanged) and pending decrements by 1.
  - A simultaneous pulse yields pending + PENALTY_SEC - 1, saturating at 255.
  - Prescaler is frozen while pending>0; no tenth ticks occur.
  - In PAUSED the penalty still drains. PAUSE/START transitions still apply during draining.
- Expiry:
  - If a tick or penalty step would leave a value <= 0, the edge writes all digits 0, pending <= 0, state <= EXPIRED.
  - A penalty step with minutes==0 and seconds==0 counts as <= 0, regardless of the tenths digit.
  - TEMPO_ACABOU and RUNNING=0 appear on the same edge that writes zero.
  - A tick from 00:00.1 expires on that tick.
- EXPIRED:
  - Digits hold zero; PAUSE and PENALTY are ignored.
  - START reloads the start value, clears prescaler, and enters RUNNING; TEMPO_ACABOU <= 0.
- AVISO (combinational from registers):
  - AVISO = (state != IDLE) && all MINUTOS digits == 0 && (10*SEGUNDOS_DECIMOS + SEGUNDOS_UNIDADE) < WARN_SEC.
  - AVISO is therefore 1 in EXPIRED whenever WARN_SEC > 0.
- Start value of all zeros: START from IDLE enters RUNNING; the first tick expires.
- No digit ever leaves its BCD range; the count never wraps below zero.

Test Plan:
1. Reset (RESET=0 two cycles), defaults with TICK_DIV=1 -> MINUTOS=2, SEGUNDOS_DECIMOS=5, SEGUNDOS_UNIDADE=9, DECIMOS=0, RUNNING=0, TEMPO_ACABOU=0, AVISO=0. Hold with START=0 for 20 cycles -> unchanged.
2. TICK_DIV=1, START pulse -> 2:58.9 after 1 tick, 2:58.0 after 10 ticks. Run from 2:00.0 -> 1:59.9. MIN_DIGITS=2, START_MIN=10: 10:00.0 -> 09:59.9.
3. START_MIN=0, START_SEC=0, START_TENTH=3, TICK_DIV=1, START -> after 3 ticks digits 0, TEMPO_ACABOU=1, RUNNING=0, AVISO=1. 10 further cycles unchanged. START -> reloads 00:00.3, RUNNING=1, TEMPO_ACABOU=0.
4. TICK_DIV=4, PAUSE asserted at prescaler count 2 for 7 cycles -> digits frozen. START -> next tenth tick exactly 2 cycles later (count resumes at 2, ticks on count 3). START and PAUSE together in PAUSED -> stays PAUSED.
5. At 0:12.5 with PENALTY_SEC=10, TICK_DIV=1000: one PENALTY pulse -> 0:02.5 exactly 10 cycles later, no tenth tick meanwhile. AVISO rises when the seconds value drops below WARN_SEC. Second pulse -> digits 0 after 3 cycles, EXPIRED, TEMPO_ACABOU=1.
6. Mid-penalty (pending=6) and mid-count, RESET=0 for one edge -> start value restored, pending 0, IDLE. Penalty pulse in IDLE -> no change.

Source files
------------

// File: rtl/temporizador_bcd_param.sv
// Mixed-radix BCD countdown timer (MM..M:SS.d) with a tenth-of-second prescaler,
// IDLE/RUNNING/PAUSED/EXPIRED control, a per-edge penalty drain and a low-time warning.
module temporizador_bcd_param #(
  parameter int MIN_DIGITS  = 1,
  parameter int TICK_DIV    = 100000,
  parameter int START_MIN   = 2,
  parameter int START_SEC   = 59,
  parameter int START_TENTH = 0,
  parameter int PENALTY_SEC = 10,
  parameter int WARN_SEC    = 10
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic                    PAUSE,
  input  logic                    PENALTY,
  output logic [3:0]              DECIMOS,
  output logic [3:0]              SEGUNDOS_UNIDADE,
  output logic [3:0]              SEGUNDOS_DECIMOS,
  output logic [4*MIN_DIGITS-1:0] MINUTOS,
  output logic                    RUNNING,
  output logic                    AVISO,
  output logic                    TEMPO_ACABOU,
  output logic [1:0]              STATE_DBG
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, EXPIRED = 2'd3} state_e;

  localparam int MW = 4 * MIN_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  function automatic logic [MW-1:0] min_to_bcd(input int v);
    logic [MW-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [MW-1:0] ST_MIN = min_to_bcd(START_MIN);
  localparam logic [3:0]    ST_SD  = 4'(START_SEC / 10);
  localparam logic [3:0]    ST_SU  = 4'(START_SEC % 10);
  localparam logic [3:0]    ST_T   = 4'(START_TENTH);

  state_e          state_q, state_d;
  logic [MW-1:0]   min_q, min_d;
  logic [3:0]      sd_q, sd_d, su_q, su_d, t_q, t_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [7:0]      pend_q, pend_d;

  logic [MW-1:0]   sm_min;
  logic [3:0]      sm_sd, sm_su;
  logic            borrow;
  logic            min_zero, sec_zero, tick_expire, pen_expire, expire;
  logic [9:0]      pend_base, pend_add, pend_sum;
  logic [7:0]      pend_sat, sec_val;

  // Value minus one second, borrowing from seconds units upward; tenths untouched.
  always_comb begin
    sm_min = min_q;
    sm_sd  = sd_q;
    sm_su  = su_q;
    borrow = 1'b0;
    if (su_q != 4'd0) sm_su = su_q - 4'd1;
    else begin
      sm_su = 4'd9;
      if (sd_q != 4'd0) sm_sd = sd_q - 4'd1;
      else begin
        sm_sd  = 4'd5;
        borrow = 1'b1;
      end
    end
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (borrow) begin
        if (min_q[4*i +: 4] != 4'd0) begin
          sm_min[4*i +: 4] = min_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end else begin
          sm_min[4*i +: 4] = 4'd9;
        end
      end
    end
  end

  assign min_zero    = (min_q == '0);
  assign sec_zero    = (sd_q == 4'd0) && (su_q == 4'd0);
  assign tick_expire = min_zero && sec_zero && (t_q <= 4'd1);
  // A one-second step expires at or below 00:01.0; 00:00.x counts as zero.
  assign pen_expire  = min_zero && (sec_zero || (sd_q == 4'd0 && su_q == 4'd1 && t_q == 4'd0));

  assign pend_base = (pend_q != 8'd0) ? {2'b00, pend_q - 8'd1} : 10'd0;
  assign pend_add  = PENALTY ? 10'(PENALTY_SEC) : 10'd0;
  assign pend_sum  = pend_base + pend_add;
  assign pend_sat  = (pend_sum > 10'd255) ? 8'd255 : pend_sum[7:0];

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sd_d    = sd_q;
    su_d    = su_q;
    t_d     = t_q;
    pre_d   = pre_q;
    pend_d  = pend_q;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && !PAUSE) begin
          state_d = RUN;
          pre_d   = '0;
        end
      end
      RUN, PAUSED: begin
        pend_d = pend_sat;
        if (pend_q != 8'd0) begin
          if (pen_expire) expire = 1'b1;
          else begin
            min_d = sm_min;
            sd_d  = sm_sd;
            su_d  = sm_su;
          end
        end else if (state_q == RUN && !PAUSE) begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (tick_expire) expire = 1'b1;
            else if (t_q != 4'd0) t_d = t_q - 4'd1;
            else begin
              t_d   = 4'd9;
              min_d = sm_min;
              sd_d  = sm_sd;
              su_d  = sm_su;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        if (state_q == RUN && PAUSE) state_d = PAUSED;
        else if (state_q == PAUSED && START && !PAUSE) state_d = RUN;
        if (expire) begin
          state_d = EXPIRED;
          min_d   = '0;
          sd_d    = 4'd0;
          su_d    = 4'd0;
          t_d     = 4'd0;
          pend_d  = 8'd0;
        end
      end
      EXPIRED: begin
        if (START && !PAUSE) begin
          state_d = RUN;
          min_d   = ST_MIN;
          sd_d    = ST_SD;
          su_d    = ST_SU;
          t_d     = ST_T;
          pre_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q <= IDLE;
      min_q   <= ST_MIN;
      sd_q    <= ST_SD;
      su_q    <= ST_SU;
      t_q     <= ST_T;
      pre_q   <= '0;
      pend_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sd_q    <= sd_d;
      su_q    <= su_d;
      t_q     <= t_d;
      pre_q   <= pre_d;
      pend_q  <= pend_d;
    end
  end

  assign sec_val          = ({4'd0, sd_q} * 8'd10) + {4'd0, su_q};
  assign DECIMOS          = t_q;
  assign SEGUNDOS_UNIDADE = su_q;
  assign SEGUNDOS_DECIMOS = sd_q;
  assign MINUTOS          = min_q;
  assign RUNNING          = (state_q == RUN);
  assign TEMPO_ACABOU     = (state_q == EXPIRED);
  assign AVISO            = (state_q != IDLE) && min_zero && (sec_val < 8'(WARN_SEC));
  assign STATE_DBG        = state_q;

endmodule

// File: tb/tb_temporizador_bcd_param.sv
// Six timer configurations driven by shared stimulus, each checked every cycle
// against a reference model that tracks the remaining time as an integer count of tenths.
module tb_temporizador_bcd_param;

  localparam int NI = 6;
  localparam int W  = 27;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAU = 2, S_EXP = 3;

  // Per-instance configuration: tick divider, start value in tenths, penalty seconds, warning seconds.
  int P_DIV[NI]   = '{1, 4, 1, 3, 2, 2};
  int P_START[NI] = '{1790, 6000, 3, 125, 60000, 0};
  int P_PEN[NI]   = '{10, 7, 10, 10, 200, 10};
  int P_WARN[NI]  = '{10, 15, 10, 10, 10, 0};

  logic CLOCK, RESET, START, PAUSE, PENALTY;
  logic [3:0] dec[NI], su[NI], sd[NI];
  logic       run[NI], avs[NI], acb[NI];
  logic [1:0] st_dbg[NI];
  logic [3:0]  m_u0, m_u2, m_u5;
  logic [7:0]  m_u1;
  logic [11:0] m_u3, m_u4;

  int m_val[NI], m_st[NI], m_pre[NI], m_pend[NI];
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  temporizador_bcd_param #(.MIN_DIGITS(1), .TICK_DIV(1)) u0 (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .PAUSE(PAUSE), .PENALTY(PENALTY),
    .DECIMOS(dec[0]), .SEGUNDOS_UNIDADE(su[0]), .SEGUNDOS_DECIMOS(sd[0]), .MINUTOS(m_u0),
    .RUNNING(run[0]), .AVISO(avs[0]), .TEMPO_ACABOU(acb[0]), .STATE_DBG(st_dbg[0]));
  temporizador_bcd_param #(.MIN_DIGITS(2), .TICK_DIV(4), .START_MIN(10), .START_SEC(0),
    .START_TENTH(0), .PENALTY_SEC(7), .WARN_SEC(15)) u1 (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .PAUSE(PAUSE), .PENALTY(PENALTY),
    .DECIMOS(dec[1]), .SEGUNDOS_UNIDADE(su[1]), .SEGUNDOS_DECIMOS(sd[1]), .MINUTOS(m_u1),
    .RUNNING(run[1]), .AVISO(avs[1]), .TEMPO_ACABOU(acb[1]), .STATE_DBG(st_dbg[1]));
  temporizador_bcd_param #(.MIN_DIGITS(1), .TICK_DIV(1), .START_MIN(0), .START_SEC(0),
    .START_TENTH(3)) u2 (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .PAUSE(PAUSE), .PENALTY(PENALTY),
    .DECIMOS(dec[2]), .SEGUNDOS_UNIDADE(su[2]), .SEGUNDOS_DECIMOS(sd[2]), .MINUTOS(m_u2),
    .RUNNING(run[2]), .AVISO(avs[2]), .TEMPO_ACABOU(acb[2]), .STATE_DBG(st_dbg[2]));
  temporizador_bcd_param #(.MIN_DIGITS(3), .TICK_DIV(3), .START_MIN(0), .START_SEC(12),
    .START_TENTH(5)) u3 (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .PAUSE(PAUSE), .PENALTY(PENALTY),
    .DECIMOS(dec[3]), .SEGUNDOS_UNIDADE(su[3]), .SEGUNDOS_DECIMOS(sd[3]), .MINUTOS(m_u3),
    .RUNNING(run[3]), .AVISO(avs[3]), .TEMPO_ACABOU(acb[3]), .STATE_DBG(st_dbg[3]));
  temporizador_bcd_param #(.MIN_DIGITS(3), .TICK_DIV(2), .START_MIN(100), .START_SEC(0),
    .START_TENTH(0), .PENALTY_SEC(200)) u4 (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .PAUSE(PAUSE), .PENALTY(PENALTY),
    .DECIMOS(dec[4]), .SEGUNDOS_UNIDADE(su[4]), .SEGUNDOS_DECIMOS(sd[4]), .MINUTOS(m_u4),
    .RUNNING(run[4]), .AVISO(avs[4]), .TEMPO_ACABOU(acb[4]), .STATE_DBG(st_dbg[4]));
  temporizador_bcd_param #(.MIN_DIGITS(1), .TICK_DIV(2), .START_MIN(0), .START_SEC(0),
    .START_TENTH(0), .WARN_SEC(0)) u5 (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .PAUSE(PAUSE), .PENALTY(PENALTY),
    .DECIMOS(dec[5]), .SEGUNDOS_UNIDADE(su[5]), .SEGUNDOS_DECIMOS(sd[5]), .MINUTOS(m_u5),
    .RUNNING(run[5]), .AVISO(avs[5]), .TEMPO_ACABOU(acb[5]), .STATE_DBG(st_dbg[5]));

  // Clock / reset block
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic logic [W-1:0] pack(input int val, input int st, input int warn);
    int mins, secs, t;
    logic [11:0] mb;
    mins = val / 600;
    secs = (val / 10) % 60;
    t    = val % 10;
    mb   = {4'(mins / 100), 4'((mins / 10) % 10), 4'(mins % 10)};
    return {mb, 4'(secs / 10), 4'(secs % 10), 4'(t), st == S_RUN,
            (st != S_IDLE) && (mins == 0) && (secs < warn), st == S_EXP};
  endfunction

  function automatic logic [W-1:0] got_word(input int k);
    logic [11:0] mb;
    case (k)
      0: mb = {8'h00, m_u0};
      1: mb = {4'h0, m_u1};
      2: mb = {8'h00, m_u2};
      3: mb = m_u3;
      4: mb = m_u4;
      default: mb = {8'h00, m_u5};
    endcase
    return {mb, sd[k], su[k], dec[k], run[k], avs[k], acb[k]};
  endfunction

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: remaining time as tenths, one update per clock edge.
  task automatic model_edge(input int k, input logic rst, input logic st, input logic pa,
                            input logic pe);
    int np, nst;
    logic ex;
    if (!rst) begin
      m_val[k] = P_START[k]; m_st[k] = S_IDLE; m_pre[k] = 0; m_pend[k] = 0;
      return;
    end
    case (m_st[k])
      S_IDLE: if (st && !pa) begin m_st[k] = S_RUN; m_pre[k] = 0; end
      S_RUN, S_PAU: begin
        ex  = 1'b0;
        nst = m_st[k];
        np  = ((m_pend[k] > 0) ? m_pend[k] - 1 : 0) + (pe ? P_PEN[k] : 0);
        if (np > 255) np = 255;
        if (m_pend[k] > 0) begin
          if (m_val[k] <= 10) ex = 1'b1;
          else m_val[k] -= 10;
        end else if (m_st[k] == S_RUN && !pa) begin
          if (m_pre[k] == P_DIV[k] - 1) begin
            m_pre[k] = 0;
            if (m_val[k] <= 1) ex = 1'b1;
            else m_val[k] -= 1;
          end else m_pre[k]++;
        end
        if (m_st[k] == S_RUN && pa) nst = S_PAU;
        else if (m_st[k] == S_PAU && st && !pa) nst = S_RUN;
        m_pend[k] = np;
        m_st[k]   = nst;
        if (ex) begin m_val[k] = 0; m_pend[k] = 0; m_st[k] = S_EXP; end
      end
      default: if (st && !pa) begin
        m_val[k] = P_START[k]; m_pre[k] = 0; m_st[k] = S_RUN;
      end
    endcase
  endtask

  // Driver: apply inputs, advance one edge, score every instance 1 time unit later.
  task automatic step(input logic rst, input logic st, input logic pa, input logic pe);
    logic [W-1:0] e;
    RESET = rst; START = st; PAUSE = pa; PENALTY = pe;
    @(posedge CLOCK);
    for (int k = 0; k < NI; k++) begin
      model_edge(k, rst, st, pa, pe);
      exp_q.push_back(pack(m_val[k], m_st[k], P_WARN[k]));
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      e = exp_q.pop_front();
      check_val($sformatf("cycle_u%0d", k), got_word(k), e);
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_val[k] = 0; m_st[k] = S_IDLE; m_pre[k] = 0; m_pend[k] = 0;
    end
    RESET = 1'b0; START = 1'b0; PAUSE = 1'b0; PENALTY = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_val("reset_u0", got_word(0), pack(1790, S_IDLE, 10));
    check_val("reset_u1", got_word(1), pack(6000, S_IDLE, 15));
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
    check_val("hold_u0", got_word(0), pack(1790, S_IDLE, 10));

    step(1, 1, 0, 0);
    check_val("start_u0", got_word(0), pack(1790, S_RUN, 10));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check_val("tick3_u0", got_word(0), pack(1787, S_RUN, 10));
    check_val("expire_u2", got_word(2), pack(0, S_EXP, 10));
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
    check_val("tick10_u0", got_word(0), pack(1780, S_RUN, 10));
    check_val("min_borrow_u1", got_word(1), pack(5998, S_RUN, 15));
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    check_val("expired_hold_u2", got_word(2), pack(0, S_EXP, 10));
    step(1, 1, 0, 0);
    check_val("restart_u2", got_word(2), pack(3, S_RUN, 10));

    step(1, 0, 0, 1);
    for (int i = 0; i < 200; i++) step(1, 0, 0, 0);
    check_val("penalty_u4", got_word(4), pack(57989, S_RUN, 10));

    for (int i = 0; i < 4000; i++)
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 14) == 0), ($urandom_range(0, 24) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
